// File: rtl/sdram_ctrl_pkg.sv
// Shared types and defaults for the SDRAM request arbiter and its refresh timer.
// Holds the arbiter state encoding and the round-robin grant helper.
package sdram_ctrl_pkg;

   localparam int RefreshRate = 1560;

   typedef enum logic [1:0] {
      IDLE,
      ISSUE,
      WAIT_RD,
      REFRESH
   } sdram_arb_states;

   // Both valid: the requester that did not own the bus last wins; otherwise the sole one.
   function automatic logic rr_pick(input logic [1:0] valid, input logic last_owner);
      return valid[1] && (!valid[0] || !last_owner);
   endfunction

endpackage

// File: rtl/sdram_refresh_timer.sv
// Free-running refresh interval timer with a pending flag, ack clear and sticky miss flag.
// expire is high in the cycle the counter sits at zero; the reload happens on that edge.
module sdram_refresh_timer
   import sdram_ctrl_pkg::*;
#(
   parameter int REFRESH_RATE = RefreshRate
) (
   input  logic clk,
   input  logic rst,
   input  logic ack,
   output logic expire,
   output logic pending,
   output logic miss
);

   localparam int CntW = (REFRESH_RATE > 2) ? $clog2(REFRESH_RATE) : 1;
   localparam logic [CntW-1:0] Reload = CntW'(REFRESH_RATE - 1);

   logic [CntW-1:0] count;

   assign expire = (count == '0);

   // NOTE: sequential state uses non-blocking assignments so every register samples pre-edge values.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         count   <= Reload;
         pending <= 1'b0;
         miss    <= 1'b0;
      end else begin
         count <= expire ? Reload : count - 1'b1;
         // A new interval beats a simultaneous ack: the refresh just granted covers the old one only.
         if (expire) begin
            pending <= 1'b1;
            if (pending && !ack)
               miss <= 1'b1;
         end else if (ack) begin
            pending <= 1'b0;
         end
      end
   end

endmodule

// File: rtl/sdram_arb.sv
// Two-port round-robin arbiter in front of an SDRAM controller, with periodic refresh.
// One transaction is in flight at a time; refresh is serviced only from IDLE.
module sdram_arb
   import sdram_ctrl_pkg::*;
#(
   parameter int REFRESH_RATE = RefreshRate,
   parameter int ADDR_W       = 25
) (
   input  logic                   clk,
   input  logic                   rst,
   input  logic [1:0]             req_valid,
   output logic [1:0]             req_ready,
   input  logic [1:0]             req_wr,
   input  logic [1:0][ADDR_W-1:0] req_addr,
   input  logic [1:0][15:0]       req_wdata,
   output logic [1:0]             rsp_valid,
   output logic [15:0]            rsp_data,
   output logic                   ctrl_req_valid,
   input  logic                   ctrl_req_ready,
   output logic                   ctrl_wr,
   output logic [ADDR_W-1:0]      ctrl_addr,
   output logic [15:0]            ctrl_wdata,
   input  logic                   ctrl_rd_valid,
   input  logic [15:0]            ctrl_rd_data,
   output logic                   ctrl_refresh_req,
   input  logic                   ctrl_refresh_ack,
   output logic                   refresh_miss
);

   sdram_arb_states state;
   logic            owner;
   logic            last_owner;
   logic            grant;
   logic            refresh_expire;
   logic            refresh_pending;
   logic            refresh_due;
   logic            refresh_ack;

   assign refresh_ack = ctrl_refresh_ack && (state == REFRESH);
   assign refresh_due = refresh_pending || refresh_expire;
   assign grant       = rr_pick(req_valid, last_owner);

   sdram_refresh_timer #(
      .REFRESH_RATE(REFRESH_RATE)
   ) u_refresh_timer (
      .clk     (clk),
      .rst     (rst),
      .ack     (refresh_ack),
      .expire  (refresh_expire),
      .pending (refresh_pending),
      .miss    (refresh_miss)
   );

   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         state            <= IDLE;
         owner            <= 1'b0;
         last_owner       <= 1'b1;
         req_ready        <= '0;
         ctrl_req_valid   <= 1'b0;
         ctrl_wr          <= 1'b0;
         ctrl_addr        <= '0;
         ctrl_wdata       <= '0;
         ctrl_refresh_req <= 1'b0;
      end else begin
         req_ready <= '0;
         case (state)
            IDLE: begin
               if (refresh_due) begin
                  state            <= REFRESH;
                  ctrl_refresh_req <= 1'b1;
               end else if (|req_valid) begin
                  state          <= ISSUE;
                  owner          <= grant;
                  last_owner     <= grant;
                  req_ready      <= 2'(2'b01 << grant);
                  ctrl_req_valid <= 1'b1;
                  ctrl_wr        <= req_wr[grant];
                  ctrl_addr      <= req_addr[grant];
                  ctrl_wdata     <= req_wdata[grant];
               end
            end
            ISSUE: begin
               if (ctrl_req_ready) begin
                  ctrl_req_valid <= 1'b0;
                  state          <= ctrl_wr ? IDLE : WAIT_RD;
               end
            end
            WAIT_RD: begin
               if (ctrl_rd_valid)
                  state <= IDLE;
            end
            REFRESH: begin
               if (ctrl_refresh_ack) begin
                  ctrl_refresh_req <= 1'b0;
                  state            <= IDLE;
               end
            end
         endcase
      end
   end

   // Read data is forwarded in the same cycle the controller returns it.
   // NOTE: every always_comb output gets a default first so no latch is inferred.
   always_comb begin
      rsp_valid = '0;
      rsp_data  = '0;
      if (state == WAIT_RD && ctrl_rd_valid) begin
         rsp_valid[owner] = 1'b1;
         rsp_data         = ctrl_rd_data;
      end
   end

endmodule

// File: tb/tb_sdram_arb.sv
// Directed bench for sdram_arb with a 16-cycle refresh interval.
// Inputs change and outputs are sampled on the falling edge; edge k = k-th rising edge after reset release.
module tb_sdram_arb;

   localparam int Rate  = 16;
   localparam int AddrW = 25;

   logic                  clk = 1'b0;
   logic                  rst = 1'b1;
   logic [1:0]            req_valid;
   logic [1:0]            req_ready;
   logic [1:0]            req_wr;
   logic [1:0][AddrW-1:0] req_addr;
   logic [1:0][15:0]      req_wdata;
   logic [1:0]            rsp_valid;
   logic [15:0]           rsp_data;
   logic                  ctrl_req_valid;
   logic                  ctrl_req_ready;
   logic                  ctrl_wr;
   logic [AddrW-1:0]      ctrl_addr;
   logic [15:0]           ctrl_wdata;
   logic                  ctrl_rd_valid;
   logic [15:0]           ctrl_rd_data;
   logic                  ctrl_refresh_req;
   logic                  ctrl_refresh_ack;
   logic                  refresh_miss;

   int n_vec = 0;
   int n_bad = 0;

   sdram_arb #(
      .REFRESH_RATE(Rate),
      .ADDR_W      (AddrW)
   ) dut (
      .clk              (clk),
      .rst              (rst),
      .req_valid        (req_valid),
      .req_ready        (req_ready),
      .req_wr           (req_wr),
      .req_addr         (req_addr),
      .req_wdata        (req_wdata),
      .rsp_valid        (rsp_valid),
      .rsp_data         (rsp_data),
      .ctrl_req_valid   (ctrl_req_valid),
      .ctrl_req_ready   (ctrl_req_ready),
      .ctrl_wr          (ctrl_wr),
      .ctrl_addr        (ctrl_addr),
      .ctrl_wdata       (ctrl_wdata),
      .ctrl_rd_valid    (ctrl_rd_valid),
      .ctrl_rd_data     (ctrl_rd_data),
      .ctrl_refresh_req (ctrl_refresh_req),
      .ctrl_refresh_ack (ctrl_refresh_ack),
      .refresh_miss     (refresh_miss)
   );

   always #5 clk = ~clk;

   task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
      n_vec++;
      if (got !== exp) begin
         n_bad++;
         $display("FAIL %s: got 0x%0h expected 0x%0h", tag, got, exp);
      end
   endtask

   task automatic cyc(input int n);
      repeat (n) @(negedge clk);
   endtask

   task automatic do_reset();
      rst              = 1'b1;
      req_valid        = '0;
      req_wr           = '0;
      req_addr         = '0;
      req_wdata        = '0;
      ctrl_req_ready   = 1'b0;
      ctrl_rd_valid    = 1'b0;
      ctrl_rd_data     = '0;
      ctrl_refresh_ack = 1'b0;
      cyc(2);
      rst = 1'b0;
   endtask

   task automatic check_quiet(input string tag);
      check({tag, ".req_ready"}, 32'(req_ready), 32'h0);
      check({tag, ".rsp_valid"}, 32'(rsp_valid), 32'h0);
      check({tag, ".rsp_data"}, 32'(rsp_data), 32'h0);
      check({tag, ".ctrl_req_valid"}, 32'(ctrl_req_valid), 32'h0);
      check({tag, ".ctrl_wr"}, 32'(ctrl_wr), 32'h0);
      check({tag, ".ctrl_addr"}, 32'(ctrl_addr), 32'h0);
      check({tag, ".ctrl_wdata"}, 32'(ctrl_wdata), 32'h0);
      check({tag, ".refresh_req"}, 32'(ctrl_refresh_req), 32'h0);
      check({tag, ".refresh_miss"}, 32'(refresh_miss), 32'h0);
   endtask

   initial begin
      #100000;
      $display("FAIL watchdog: simulation time limit reached");
      $fatal(1, "watchdog");
   end

   initial begin
      // Reset state and single read from requester 0.
      do_reset();
      check_quiet("reset");
      req_valid      = 2'b01;
      req_wr         = 2'b00;
      req_addr[0]    = 25'h0000123;
      ctrl_req_ready = 1'b1;
      cyc(1);
      check("rd.req_ready", 32'(req_ready), 32'h1);
      check("rd.ctrl_req_valid", 32'(ctrl_req_valid), 32'h1);
      check("rd.ctrl_addr", 32'(ctrl_addr), 32'h123);
      check("rd.ctrl_wr", 32'(ctrl_wr), 32'h0);
      req_valid = 2'b00;
      cyc(1);
      check("rd.accepted", 32'(ctrl_req_valid), 32'h0);
      check("rd.ready_pulse", 32'(req_ready), 32'h0);
      cyc(1);
      check("rd.no_early_rsp", 32'(rsp_valid), 32'h0);
      ctrl_rd_valid = 1'b1;
      ctrl_rd_data  = 16'hBEEF;
      #1;
      check("rd.rsp_valid", 32'(rsp_valid), 32'h1);
      check("rd.rsp_data", 32'(rsp_data), 32'hBEEF);
      cyc(1);
      #1;
      check("stray_rd.rsp_valid", 32'(rsp_valid), 32'h0);
      ctrl_rd_valid = 1'b0;

      // Both requesters writing continuously: grants alternate 0,1,0,1.
      do_reset();
      req_wr         = 2'b11;
      req_addr[0]    = 25'h000000A;
      req_addr[1]    = 25'h000000B;
      req_wdata[0]   = 16'h1111;
      req_wdata[1]   = 16'h2222;
      ctrl_req_ready = 1'b1;
      req_valid      = 2'b11;
      for (int k = 0; k < 4; k++) begin
         int waited;
         waited = 0;
         do begin
            cyc(1);
            waited++;
         end while (req_ready == 2'b00 && waited < 8);
         check($sformatf("rr%0d.grant", k), 32'(req_ready), (k % 2 == 1) ? 32'h2 : 32'h1);
         check($sformatf("rr%0d.addr", k), 32'(ctrl_addr), (k % 2 == 1) ? 32'hB : 32'hA);
         check($sformatf("rr%0d.wdata", k), 32'(ctrl_wdata), (k % 2 == 1) ? 32'h2222 : 32'h1111);
         check($sformatf("rr%0d.latency", k), 32'(waited), (k == 0) ? 32'd1 : 32'd2);
      end
      req_valid = 2'b00;

      // Idle bus refresh timing: request at edge 16, ack at 17, next at 32.
      do_reset();
      cyc(15);
      check("ref.before16", 32'(ctrl_refresh_req), 32'h0);
      cyc(1);
      check("ref.at16", 32'(ctrl_refresh_req), 32'h1);
      ctrl_refresh_ack = 1'b1;
      cyc(1);
      ctrl_refresh_ack = 1'b0;
      check("ref.acked", 32'(ctrl_refresh_req), 32'h0);
      cyc(14);
      check("ref.before32", 32'(ctrl_refresh_req), 32'h0);
      cyc(1);
      check("ref.at32", 32'(ctrl_refresh_req), 32'h1);
      check("ref.no_miss", 32'(refresh_miss), 32'h0);

      // Ack coincides with the next expiry: pending survives, no miss.
      do_reset();
      cyc(16);
      check("coinc.req16", 32'(ctrl_refresh_req), 32'h1);
      cyc(15);
      ctrl_refresh_ack = 1'b1;
      cyc(1);
      ctrl_refresh_ack = 1'b0;
      check("coinc.req_dropped", 32'(ctrl_refresh_req), 32'h0);
      check("coinc.no_miss", 32'(refresh_miss), 32'h0);
      cyc(1);
      check("coinc.req_again", 32'(ctrl_refresh_req), 32'h1);
      check("coinc.still_no_miss", 32'(refresh_miss), 32'h0);

      // Ack withheld 20 cycles: miss at edge 32, sticky until reset.
      do_reset();
      cyc(16);
      check("miss.req16", 32'(ctrl_refresh_req), 32'h1);
      cyc(15);
      check("miss.before32", 32'(refresh_miss), 32'h0);
      cyc(1);
      check("miss.at32", 32'(refresh_miss), 32'h1);
      cyc(4);
      ctrl_refresh_ack = 1'b1;
      cyc(1);
      ctrl_refresh_ack = 1'b0;
      check("miss.req_cleared", 32'(ctrl_refresh_req), 32'h0);
      check("miss.sticky", 32'(refresh_miss), 32'h1);
      cyc(3);
      check("miss.sticky_later", 32'(refresh_miss), 32'h1);
      rst = 1'b1;
      #1;
      check("miss.cleared_by_rst", 32'(refresh_miss), 32'h0);

      // Refresh comes due during WAIT_RD while requester 1 waits.
      do_reset();
      ctrl_req_ready = 1'b1;
      req_wr         = 2'b10;
      req_addr[0]    = 25'h0000077;
      req_addr[1]    = 25'h0000099;
      req_wdata[1]   = 16'hCAFE;
      cyc(12);
      req_valid = 2'b11;
      cyc(1);
      check("mix.grant0", 32'(req_ready), 32'h1);
      check("mix.rd_addr", 32'(ctrl_addr), 32'h77);
      req_valid = 2'b10;
      cyc(1);
      check("mix.accepted", 32'(ctrl_req_valid), 32'h0);
      cyc(3);
      check("mix.no_abort", 32'(ctrl_refresh_req), 32'h0);
      ctrl_rd_valid = 1'b1;
      ctrl_rd_data  = 16'h5A5A;
      #1;
      check("mix.rsp_valid", 32'(rsp_valid), 32'h1);
      check("mix.rsp_data", 32'(rsp_data), 32'h5A5A);
      cyc(1);
      ctrl_rd_valid = 1'b0;
      check("mix.idle_ready", 32'(req_ready), 32'h0);
      cyc(1);
      check("mix.refresh_first", 32'(ctrl_refresh_req), 32'h1);
      check("mix.refresh_no_grant", 32'(req_ready), 32'h0);
      ctrl_refresh_ack = 1'b1;
      cyc(1);
      ctrl_refresh_ack = 1'b0;
      check("mix.refresh_done", 32'(ctrl_refresh_req), 32'h0);
      check("mix.still_no_grant", 32'(req_ready), 32'h0);
      cyc(1);
      check("mix.grant1", 32'(req_ready), 32'h2);
      check("mix.wr", 32'(ctrl_wr), 32'h1);
      check("mix.wr_addr", 32'(ctrl_addr), 32'h99);
      check("mix.wr_data", 32'(ctrl_wdata), 32'hCAFE);
      req_valid = 2'b00;

      // Reset while waiting for read data drops the transaction.
      do_reset();
      ctrl_req_ready = 1'b1;
      req_valid      = 2'b01;
      req_addr[0]    = 25'h0000055;
      cyc(1);
      req_valid = 2'b00;
      cyc(1);
      check("rstmid.in_wait", 32'(ctrl_req_valid), 32'h0);
      rst = 1'b1;
      #1;
      check_quiet("rstmid");
      cyc(1);
      rst           = 1'b0;
      ctrl_rd_valid = 1'b1;
      ctrl_rd_data  = 16'h1234;
      #1;
      check("rstmid.no_rsp", 32'(rsp_valid), 32'h0);
      check("rstmid.no_data", 32'(rsp_data), 32'h0);
      cyc(1);
      check("rstmid.no_rsp_later", 32'(rsp_valid), 32'h0);
      ctrl_rd_valid = 1'b0;
      req_valid     = 2'b10;
      req_wr        = 2'b10;
      cyc(1);
      check("rstmid.idle_grant", 32'(req_ready), 32'h2);
      req_valid = 2'b00;
      cyc(2);

      $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_bad);
      $finish;
   end

endmodule
